// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
// Optional signed-overflow output is enabled with SERIAL_ADDSUB_OVF_EN.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Start/done request bus between a requester and the serial add/subtract engine.
// The ovf signal exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_ctrl_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout_bout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf;
`endif

`ifdef SERIAL_ADDSUB_OVF_EN
   modport master (
      output start, op, a, b,
      input  busy, done, result, cout_bout, ovf
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout_bout, ovf
   );
`else
   modport master (
      output start, op, a, b,
      input  busy, done, result, cout_bout
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout_bout
   );
`endif

endinterface

// File: rtl/serial_addsub_ctrl_cell.sv
// Combinational 1-bit full-adder / full-subtractor cell; sel picks add or subtract.
module addsub_bit_cell
   import serial_addsub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin_bin,
   input  logic sel,
   output logic sum_diff,
   output logic cout_bout
);

   // The sum and difference bits are the same XOR; only the carry/borrow differs.
   always_comb begin
      sum_diff  = a ^ b ^ cin_bin;
      cout_bout = (a & b) | (cin_bin & (a ^ b));
      if (sel == OP_SUB) begin
         cout_bout = (~a & b) | (cin_bin & ~(a ^ b));
      end
   end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract engine: one 1-bit cell sequenced LSB first over WIDTH cycles.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output.
module serial_addsub_ctrl
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_addsub_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   res_sh;
   logic [WIDTH-1:0]   res_next;
   logic               cb_q;
   logic               op_r;
   logic [CNT_W-1:0]   cnt;
   logic               last_bit;
   logic [WIDTH-1:0]   result_q;
   logic               cout_q;
   logic               cell_bit;
   logic               cell_cb;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic               ovf_q;
`endif

   addsub_bit_cell u_cell (
      .a         (a_sh[0]),
      .b         (b_sh[0]),
      .cin_bin   (cb_q),
      .sel       (op_r),
      .sum_diff  (cell_bit),
      .cout_bout (cell_cb)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign res_next = {cell_bit, res_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = RUN;
         RUN:     if (last_bit)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The final RUN edge already holds the last cell output, so the result
   // registers load from the shift path on the same edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         cb_q     <= 1'b0;
         op_r     <= OP_ADD;
         cnt      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh <= bus.a;
                  b_sh <= bus.b;
                  op_r <= bus.op;
                  cb_q <= 1'b0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               cb_q   <= cell_cb;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  result_q <= res_next;
                  cout_q   <= cell_cb;
`ifdef SERIAL_ADDSUB_OVF_EN
                  // cb_q is the carry/borrow into the MSB during the last bit.
                  ovf_q    <= cb_q ^ cell_cb;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.result    = result_q;
   assign bus.cout_bout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule
